clock_div_ctrl: RTL and testbench
=================================

# clock_div_ctrl

Programmable clock-divider controller: owns a divide-by-N counter core and sequences start, stop and ratio changes so clkout never produces a runt or stretched pulse. Software or another block issues configuration requests over a valid/ready handshake. Changes take effect only at an output-period boundary. It sits between the configuration source and the logic clocked or enabled by the divided clock.

## Interface
- CNT_W, 8, width of divide ratio and period counter; legal ratios 2..2^CNT_W-1
- clkin  input  1  reference clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- cfg_valid  input  1  configuration request valid
- cfg_ready  output  1  controller can accept a request this cycle
- cfg_en  input  1  1 = run at cfg_div, 0 = stop
- cfg_div  input  CNT_W  requested divide ratio N
- clkout  output  1  divided clock, registered
- tick  output  1  one-cycle pulse on the first clkin cycle of each clkout period
- running  output  1  divider active (RUN or PEND)
- cfg_err  output  1  one-cycle pulse: accepted request had cfg_en=1 and cfg_div<2

## Operation
- Transfer occurs on a rising edge with cfg_valid && cfg_ready.
- cfg_ready = 1 in IDLE and RUN, 0 in PEND.
- States: IDLE, RUN, PEND.
- IDLE: cnt=0, clkout=0, tick=0.
  - Accept with cfg_en=1 and legal div: div_q<=cfg_div, cnt<=0, go RUN.
  - Accept with cfg_en=0: no change.
- RUN: cnt counts 0..div_q-1, then wraps to 0.
  - Accept: store pend_en/pend_div, go PEND. The current period finishes unchanged.
- PEND: continue the current period.
  - At the wrap edge (cnt==div_q-1) with pend_en=1: load div_q<=pend_div, cnt<=0, go RUN.
  - At the wrap edge with pend_en=0: go IDLE, clkout<=0.
- Illegal request (cfg_en=1, cfg_div 0 or 1):
  - Handshake completes, cfg_err pulses on the cycle after acceptance.
  - The request is discarded; state and ratio are unchanged, and no PEND entry is made.
- clkout = 1 while cnt < floor(div_q/2), else 0. Resulting duty:
  - N=2: 1 high / 1 low
  - N=3: 1 high / 2 low
  - N=5: 2 high / 3 low
- tick = 1 when running and cnt==0.
- Reset asserted (any time, including mid-period or in PEND): state=IDLE, cnt=0, div_q=0, pend cleared, clkout=0, tick=0, cfg_err=0, running=0. cfg_ready is 1 once reset deasserts.

## Timing
- Start latency: request accepted at edge E.
  - After E: running=1, cnt=0, clkout=1, tick=1.
  - First rising clkout is visible one clkin period after the accept edge's setup.
- Period is exactly div_q clkin cycles; tick repeats every div_q cycles.
- Ratio change: new period begins on the edge after the old period's last cycle (cnt==old_N-1). No partial period at either ratio.
- Stop: clkout held 0 from the edge ending the current period; running falls on that same edge.
- Simultaneous wrap and acceptance in RUN:
  - The request goes to PEND.
  - It applies at the next wrap, not the current one.
- All outputs are registered; there is no combinational path from cfg_* to clkout or tick. The exception is cfg_ready, which is decoded from state.

## Structure
- Package clock_div_pkg:
  - state enum {IDLE, RUN, PEND}
  - default CNT_W localparam
  - MIN_DIV = 2
- Sub-module clock_div_core:
  - Contains cnt, clkout and tick generation.
  - Inputs: run, load, div.
  - Output: wrap strobe to the controller FSM.
- Top clock_div_ctrl holds the FSM, handshake, pending registers and error pulse.

## Test plan
- Reset, then accept {en=1, div=3}: clkout pattern 1,0,0 repeating; tick every 3 cycles; running=1.
- While running div=3, request div=5 mid-period: the current 3-cycle period completes; next periods show 2 high / 3 low; cfg_ready=0 until the switch.
- Request {en=0} while running div=4: clkout finishes 2 high / 2 low, then stays 0; running falls at the wrap edge.
- Request {en=1, div=1} in RUN at div=2: handshake completes, cfg_err pulses once, div=2 output continues undisturbed.
- Assert reset during PEND with clkout=1: clkout, tick, running go 0 immediately (asynchronously); after release, state is IDLE and cfg_ready=1.
- Request accepted on the exact wrap cycle of div=2: output completes one more div=2 period before the new ratio applies.

Source files
------------

// File: rtl/clock_div_pkg.sv
// clock_div_pkg
// Shared definitions for the programmable clock divider.
//   state_t   : controller FSM states (IDLE, RUN, PEND)
//   CNT_W_DEF : default width of the divide ratio and the period counter
//   MIN_DIV   : smallest legal divide ratio
package clock_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int MIN_DIV   = 2;

endpackage

// File: rtl/clock_div_core.sv
// clock_div_core
// Divide-by-N counter with a registered divided clock and period tick.
// Ports:
//   clkin  in   reference clock
//   reset  in   asynchronous active-low reset
//   run    in   divider active during the coming cycle
//   load   in   load div as the new ratio and restart the period at cnt=0
//   div    in   ratio to load (CNT_W bits)
//   clkout out  divided clock, high while cnt < floor(div/2)
//   tick   out  high on the first cycle of every output period
//   wrap   out  current cycle is the last one of the period (cnt == div-1)
module clock_div_core
    import clock_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             clkout,
    output logic             tick,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;
    logic             run_q;
    logic             clkout_q;
    logic             tick_q;

    assign wrap = run_q && (cnt_q == (div_q - ONE));

    always_comb begin
        div_d = load ? div : div_q;
        if (!run || load || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // clkout and tick are registered from the next counter value so they
    // line up with cnt in the same cycle, with no decode glitches.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            div_q    <= '0;
            run_q    <= 1'b0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            run_q    <= run;
            clkout_q <= run && (cnt_d < (div_d >> 1));
            tick_q   <= run && (cnt_d == '0);
        end
    end

    assign clkout = clkout_q;
    assign tick   = tick_q;

endmodule

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl
// Sequences start, stop and ratio changes of the divider so that changes
// only take effect on an output-period boundary.
// Ports:
//   clkin     in   reference clock
//   reset     in   asynchronous active-low reset
//   cfg_valid in   configuration request valid
//   cfg_ready out  request can be accepted (IDLE or RUN)
//   cfg_en    in   1 = run at cfg_div, 0 = stop
//   cfg_div   in   requested divide ratio (CNT_W bits)
//   clkout    out  divided clock
//   tick      out  pulse on the first cycle of each clkout period
//   running   out  divider active (RUN or PEND)
//   cfg_err   out  pulse the cycle after an accepted enable with ratio < 2
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clkout,
    output logic             tick,
    output logic             running,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);

    state_t           state_q;
    state_t           state_d;
    logic             pend_en_q;
    logic [CNT_W-1:0] pend_div_q;
    logic             pend_set;
    logic             cfg_err_q;
    logic             accept;
    logic             bad_req;
    logic             core_run;
    logic             core_load;
    logic [CNT_W-1:0] core_div;
    logic             wrap;

    assign cfg_ready = (state_q != PEND);
    assign running   = (state_q != IDLE);
    assign accept    = cfg_valid && cfg_ready;
    // An enable with an unusable ratio is consumed but otherwise ignored.
    assign bad_req   = cfg_en && (cfg_div < MIN_DIV_W);

    always_comb begin
        state_d   = state_q;
        core_run  = 1'b0;
        core_load = 1'b0;
        core_div  = pend_div_q;
        pend_set  = 1'b0;
        case (state_q)
            IDLE: begin
                core_div = cfg_div;
                if (accept && cfg_en && !bad_req) begin
                    core_run  = 1'b1;
                    core_load = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                core_run = 1'b1;
                // A request landing on the wrap edge still waits for the
                // following wrap, so the period just started runs whole.
                if (accept && !bad_req) begin
                    pend_set = 1'b1;
                    state_d  = PEND;
                end
            end
            PEND: begin
                core_run = 1'b1;
                if (wrap) begin
                    if (pend_en_q) begin
                        core_load = 1'b1;
                        state_d   = RUN;
                    end else begin
                        core_run = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_en_q  <= 1'b0;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= accept && bad_req;
            if (pend_set) begin
                pend_en_q  <= cfg_en;
                pend_div_q <= cfg_div;
            end
        end
    end

    assign cfg_err = cfg_err_q;

    clock_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clkin  (clkin),
        .reset  (reset),
        .run    (core_run),
        .load   (core_load),
        .div    (core_div),
        .clkout (clkout),
        .tick   (tick),
        .wrap   (wrap)
    );

endmodule

// File: tb/tb_clock_div_ctrl.sv
module tb_clock_div_ctrl;

    logic       clkin;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_en;
    logic [7:0] cfg_div;
    logic       clkout;
    logic       tick;
    logic       running;
    logic       cfg_err;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic clkout;
        logic tick;
        logic running;
        logic ready;
        logic err;
        logic chk_rdy;
    } exp_t;

    exp_t sb[$];

    // reference model state: 0 = idle, 1 = run, 2 = pending
    int m_st;
    int m_cnt;
    int m_div;
    int m_pen;
    int m_pdiv;

    clock_div_ctrl #(.CNT_W(8)) dut (
        .clkin     (clkin),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .clkout    (clkout),
        .tick      (tick),
        .running   (running),
        .cfg_err   (cfg_err)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clkin edge of the reference behaviour; pushes what the outputs
    // must show after this edge.
    task model_step();
        exp_t e;
        logic acc;
        logic ill;
        logic wr;
        if (!reset) begin
            m_st = 0; m_cnt = 0; m_div = 0; m_pen = 0; m_pdiv = 0;
            e = '{clkout: 1'b0, tick: 1'b0, running: 1'b0, ready: 1'b1, err: 1'b0, chk_rdy: 1'b0};
            sb.push_back(e);
            return;
        end
        acc = cfg_valid && (m_st != 2);
        ill = acc && cfg_en && (cfg_div < 8'd2);
        wr  = (m_st != 0) && (m_cnt == m_div - 1);
        case (m_st)
            0: begin
                m_cnt = 0;
                if (acc && cfg_en && !ill) begin
                    m_div = int'(cfg_div);
                    m_st  = 1;
                end
            end
            1: begin
                m_cnt = wr ? 0 : m_cnt + 1;
                if (acc && !ill) begin
                    m_pen  = int'(cfg_en);
                    m_pdiv = int'(cfg_div);
                    m_st   = 2;
                end
            end
            default: begin
                if (wr) begin
                    m_cnt = 0;
                    if (m_pen != 0) begin
                        m_div = m_pdiv;
                        m_st  = 1;
                    end else begin
                        m_st = 0;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        endcase
        e.running = (m_st != 0);
        e.clkout  = e.running && (m_cnt < m_div / 2);
        e.tick    = e.running && (m_cnt == 0);
        e.ready   = (m_st != 2);
        e.err     = ill;
        e.chk_rdy = 1'b1;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clkin);
            model_step();
            #1;
            if (sb.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check("clkout", {31'd0, clkout}, {31'd0, e.clkout});
                check("tick", {31'd0, tick}, {31'd0, e.tick});
                check("running", {31'd0, running}, {31'd0, e.running});
                check("cfg_err", {31'd0, cfg_err}, {31'd0, e.err});
                if (e.chk_rdy) check("cfg_ready", {31'd0, cfg_ready}, {31'd0, e.ready});
            end
        end
    end

    // Called and returns at a negedge; request is held until accepted.
    task automatic send(input logic en, input logic [7:0] div);
        int n;
        cfg_valid = 1'b1;
        cfg_en    = en;
        cfg_div   = div;
        n = 0;
        while (!cfg_ready && n < 50) begin
            @(negedge clkin);
            n++;
        end
        if (n >= 50) check("handshake_timeout", 32'd0, 32'd1);
        @(posedge clkin);
        @(negedge clkin);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clkin);
    endtask

    initial begin : stim
        int n;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_en    = 1'b0;
        cfg_div   = 8'd0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);

        // start at /3
        send(1'b1, 8'd3);
        wait_cycles(9);
        // mid-period change to /5
        wait_cycles(1);
        send(1'b1, 8'd5);
        wait_cycles(15);
        // /4 then stop
        send(1'b1, 8'd4);
        wait_cycles(10);
        send(1'b0, 8'd0);
        wait_cycles(10);
        // illegal request while running /2
        send(1'b1, 8'd2);
        wait_cycles(4);
        send(1'b1, 8'd1);
        wait_cycles(6);
        // request accepted exactly on the /2 wrap edge
        n = 0;
        while (!(running && !clkout) && n < 20) begin
            @(negedge clkin);
            n++;
        end
        if (n >= 20) check("wrap_search_timeout", 32'd0, 32'd1);
        send(1'b1, 8'd3);
        wait_cycles(12);

        // async reset while pending with clkout high
        send(1'b1, 8'd5);
        wait_cycles(12);
        n = 0;
        while (!tick && n < 20) begin
            @(negedge clkin);
            n++;
        end
        if (n >= 20) check("tick_search_timeout", 32'd0, 32'd1);
        send(1'b1, 8'd6);
        check("pend_clkout_high", {31'd0, clkout}, 32'd1);
        check("pend_not_ready", {31'd0, cfg_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async_clkout", {31'd0, clkout}, 32'd0);
        check("async_tick", {31'd0, tick}, 32'd0);
        check("async_running", {31'd0, running}, 32'd0);
        wait_cycles(2);
        reset = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, cfg_ready}, 32'd1);
        @(negedge clkin);

        // requests in idle: stop is a no-op, illegal ratio flags an error
        send(1'b0, 8'd7);
        wait_cycles(3);
        send(1'b1, 8'd0);
        wait_cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
